// File: rtl/ptw_pkg.sv
// Shared types and constants for the Sv32-style page-table walker.
package ptw_pkg;

  typedef enum logic [2:0] {
    IDLE,
    L1_REQ,
    L1_WAIT,
    L2_REQ,
    L2_WAIT,
    RESP
  } state_e;

  localparam int PTE_V = 0;
  localparam int PTE_R = 1;
  localparam int PTE_W = 2;
  localparam int PTE_X = 3;

  localparam int PTE_SIZE_LOG2 = 2;
  localparam int VPN1_W        = 10;
  localparam int VPN0_W        = 10;

  typedef struct packed {
    logic [11:0] ppn1;
    logic [9:0]  ppn0;
    logic [1:0]  rsw;
    logic [7:0]  flags;
  } pte_t;

  // Byte address of a PTE: table base page number plus scaled VPN index.
  function automatic logic [31:0] pte_addr(input logic [19:0] ppn, input logic [VPN0_W-1:0] vpn);
    return {ppn, vpn, {PTE_SIZE_LOG2{1'b0}}};
  endfunction

endpackage

// File: rtl/ptw_pte_check.sv
// Combinational PTE classifier: flags a PTE as fault, leaf or next-level pointer.
module ptw_pte_check
  import ptw_pkg::*;
(
  input  logic [31:0] pte_i,
  input  logic        level_i,
  output logic        fault_o,
  output logic        is_leaf_o,
  output logic        is_ptr_o,
  output logic [19:0] next_ppn_o
);

  pte_t pte;
  logic v, r, w, x;
  logic malformed;
  logic unused_bits;

  assign pte = pte_t'(pte_i);
  assign v   = pte.flags[PTE_V];
  assign r   = pte.flags[PTE_R];
  assign w   = pte.flags[PTE_W];
  assign x   = pte.flags[PTE_X];

  // Write-only permission is a reserved encoding and faults like an invalid PTE.
  assign malformed  = !v || (!r && w);
  assign is_leaf_o  = !malformed && (r || x);
  assign is_ptr_o   = !malformed && !r && !x && !level_i;
  assign fault_o    = malformed || (level_i && !(r || x));

  // Only 32 bits of physical address exist, so ppn1[11:10] falls off.
  assign next_ppn_o = {pte.ppn1[9:0], pte.ppn0};

  assign unused_bits = ^{pte.ppn1[11:10], pte.rsw, pte.flags[7:4]};

endmodule

// File: rtl/ptw.sv
// Two-level Sv32-style page-table walker, one walk in flight.
// Define PTW_SUPERPAGE_EN to return valid L1 leaves as 4 MiB superpages.
module ptw
  import ptw_pkg::*;
#(
  parameter logic [19:0] ROOT_PPN = 20'h00010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ptw_req_valid_i,
  output logic        ptw_req_ready_o,
  input  logic [31:0] ptw_vaddr_i,
  output logic        ptw_resp_valid_o,
  input  logic        ptw_resp_ready_i,
  output logic [31:0] ptw_pte_o,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_addr_o,
  input  logic        mem_resp_valid_i,
  output logic        mem_resp_ready_o,
  input  logic [31:0] mem_data_i
);

  state_e      state_q;
  logic        req_ready_q;
  logic        mem_req_valid_q;
  logic        mem_resp_ready_q;
  logic        resp_valid_q;
  logic [31:0] pte_q;
  logic [31:0] addr_q;
  logic [31:0] vaddr_q;

  logic        chk_fault;
  logic        chk_leaf;
  logic        chk_ptr;
  logic [19:0] chk_next_ppn;
  logic        unused_vaddr;

  ptw_pte_check u_pte_check (
    .pte_i      (mem_data_i),
    .level_i    (state_q == L2_WAIT),
    .fault_o    (chk_fault),
    .is_leaf_o  (chk_leaf),
    .is_ptr_o   (chk_ptr),
    .next_ppn_o (chk_next_ppn)
  );

  // All handshake outputs are registered and change together with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      req_ready_q      <= 1'b0;
      mem_req_valid_q  <= 1'b0;
      mem_resp_ready_q <= 1'b0;
      resp_valid_q     <= 1'b0;
      pte_q            <= '0;
      addr_q           <= '0;
      vaddr_q          <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (ptw_req_valid_i && req_ready_q) begin
            vaddr_q         <= ptw_vaddr_i;
            pte_q           <= '0;
            req_ready_q     <= 1'b0;
            mem_req_valid_q <= 1'b1;
            addr_q          <= pte_addr(ROOT_PPN, ptw_vaddr_i[31:22]);
            state_q         <= L1_REQ;
          end
        end
        L1_REQ: begin
          if (mem_req_ready_i) begin
            mem_req_valid_q  <= 1'b0;
            mem_resp_ready_q <= 1'b1;
            state_q          <= L1_WAIT;
          end
        end
        L1_WAIT: begin
          if (mem_resp_valid_i) begin
            mem_resp_ready_q <= 1'b0;
            if (chk_fault) begin
              pte_q        <= '0;
              resp_valid_q <= 1'b1;
              state_q      <= RESP;
            end else if (chk_ptr) begin
              addr_q          <= pte_addr(chk_next_ppn, vaddr_q[21:12]);
              mem_req_valid_q <= 1'b1;
              state_q         <= L2_REQ;
            end else begin
`ifdef PTW_SUPERPAGE_EN
              pte_q <= mem_data_i;
`else
              pte_q <= '0;
`endif
              resp_valid_q <= 1'b1;
              state_q      <= RESP;
            end
          end
        end
        L2_REQ: begin
          if (mem_req_ready_i) begin
            mem_req_valid_q  <= 1'b0;
            mem_resp_ready_q <= 1'b1;
            state_q          <= L2_WAIT;
          end
        end
        L2_WAIT: begin
          if (mem_resp_valid_i) begin
            mem_resp_ready_q <= 1'b0;
            pte_q            <= chk_leaf ? mem_data_i : '0;
            resp_valid_q     <= 1'b1;
            state_q          <= RESP;
          end
        end
        RESP: begin
          if (ptw_resp_ready_i) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q          <= IDLE;
          req_ready_q      <= 1'b0;
          mem_req_valid_q  <= 1'b0;
          mem_resp_ready_q <= 1'b0;
          resp_valid_q     <= 1'b0;
        end
      endcase
    end
  end

  assign ptw_req_ready_o  = req_ready_q;
  assign ptw_resp_valid_o = resp_valid_q;
  assign ptw_pte_o        = pte_q;
  assign mem_req_valid_o  = mem_req_valid_q;
  assign mem_addr_o       = addr_q;
  assign mem_resp_ready_o = mem_resp_ready_q;

  assign unused_vaddr = ^{vaddr_q[31:22], vaddr_q[11:0]};

endmodule

// File: tb/tb_ptw.sv
// Directed self-checking bench for the ptw walker with a one-cycle-latency memory model.
// Expected superpage behaviour follows PTW_SUPERPAGE_EN.
module tb_ptw;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ptw_req_valid_i = 1'b0;
  logic        ptw_req_ready_o;
  logic [31:0] ptw_vaddr_i = '0;
  logic        ptw_resp_valid_o;
  logic        ptw_resp_ready_i = 1'b0;
  logic [31:0] ptw_pte_o;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i = 1'b1;
  logic [31:0] mem_addr_o;
  logic        mem_resp_valid_i;
  logic        mem_resp_ready_o;
  logic [31:0] mem_data_i;

  logic        respValidAuto = 1'b0;
  logic        manualRespValid = 1'b0;
  logic        respEnable = 1'b1;
  logic [31:0] respDataAuto = '0;
  logic [31:0] pendAddr = '0;
  bit          pending = 1'b0;
  bit          reqFire = 1'b0;
  bit          respFire = 1'b0;
  bit          rstSeen = 1'b1;
  int          reqCount = 0;
  logic [31:0] reqLog[$];
  logic [31:0] memory[logic [31:0]];

  int errors = 0;
  int checks = 0;

`ifdef PTW_SUPERPAGE_EN
  localparam logic [31:0] SUPER_EXP = 32'h0040_000F;
`else
  localparam logic [31:0] SUPER_EXP = 32'h0000_0000;
`endif

  always #5 clk = ~clk;

  assign mem_resp_valid_i = respValidAuto | manualRespValid;
  assign mem_data_i       = manualRespValid ? 32'hFFFF_FFFF : respDataAuto;

  ptw dut (
    .clk              (clk),
    .rst              (rst),
    .ptw_req_valid_i  (ptw_req_valid_i),
    .ptw_req_ready_o  (ptw_req_ready_o),
    .ptw_vaddr_i      (ptw_vaddr_i),
    .ptw_resp_valid_o (ptw_resp_valid_o),
    .ptw_resp_ready_i (ptw_resp_ready_i),
    .ptw_pte_o        (ptw_pte_o),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_addr_o       (mem_addr_o),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_resp_ready_o (mem_resp_ready_o),
    .mem_data_i       (mem_data_i)
  );

  // Record handshakes as the DUT sees them on the rising edge.
  always @(posedge clk) begin
    rstSeen  = rst;
    reqFire  = mem_req_valid_o && mem_req_ready_i;
    respFire = mem_resp_valid_i && mem_resp_ready_o;
    if (reqFire) begin
      reqCount++;
      reqLog.push_back(mem_addr_o);
    end
  end

  // Memory model: answer each accepted read one cycle later.
  always @(negedge clk) begin
    if (rstSeen) begin
      pending       = 1'b0;
      respValidAuto = 1'b0;
    end else begin
      if (respFire) respValidAuto = 1'b0;
      if (reqFire) begin
        pending  = 1'b1;
        pendAddr = reqLog[reqLog.size()-1];
      end
      if (pending && respEnable && !respValidAuto) begin
        respValidAuto = 1'b1;
        respDataAuto  = memory.exists(pendAddr) ? memory[pendAddr] : 32'h0;
        pending       = 1'b0;
      end
    end
  end

  function automatic logic [31:0] logAt(input int idx);
    return (idx < reqLog.size()) ? reqLog[idx] : 32'hFFFF_FFFF;
  endfunction

  // Runs one full walk from a falling edge; cycles counts falling edges from acceptance to response.
  task automatic applyStimulus(input logic [31:0] va, output logic [31:0] pte,
                               output logic [31:0] pteAtAccept, output int cycles,
                               output bit timedOut);
    int waitCnt;
    timedOut    = 1'b0;
    cycles      = 0;
    pte         = 32'hFFFF_FFFF;
    pteAtAccept = 32'hFFFF_FFFF;
    waitCnt     = 0;
    while (!ptw_req_ready_o && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!ptw_req_ready_o) begin
      timedOut = 1'b1;
      return;
    end
    ptw_req_valid_i = 1'b1;
    ptw_vaddr_i     = va;
    @(negedge clk);
    ptw_req_valid_i = 1'b0;
    pteAtAccept     = ptw_pte_o;
    cycles          = 1;
    while (!ptw_resp_valid_o && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    if (!ptw_resp_valid_o) begin
      timedOut = 1'b1;
      return;
    end
    pte = ptw_pte_o;
    ptw_resp_ready_i = 1'b1;
    @(negedge clk);
    ptw_resp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({ptw_req_ready_o, ptw_resp_valid_o, mem_req_valid_o, mem_resp_ready_o} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_handshakes: got %b expected 0000",
               {ptw_req_ready_o, ptw_resp_valid_o, mem_req_valid_o, mem_resp_ready_o});
    end
    checks++;
    if (ptw_pte_o !== 32'h0 || mem_addr_o !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_data: got pte=%h addr=%h expected 0/0", ptw_pte_o, mem_addr_o);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ptw_req_ready_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ready_after: got %b expected 1", ptw_req_ready_o);
    end
  endtask

  task automatic test_two_level();
    logic [31:0] pte, pteAcc;
    int cycles, base;
    bit to;
    base = reqCount;
    applyStimulus(32'hC000_4000, pte, pteAcc, cycles, to);
    checks++;
    if (to !== 1'b0) begin errors++; $display("[TB] FAIL walk1_timeout: got %b expected 0", to); end
    checks++;
    if (pte !== 32'hBEEF_000B) begin errors++; $display("[TB] FAIL walk1_pte: got %h expected beef000b", pte); end
    checks++;
    if (cycles !== 5) begin errors++; $display("[TB] FAIL walk1_latency: got %0d expected 5", cycles); end
    checks++;
    if (reqCount - base !== 2) begin errors++; $display("[TB] FAIL walk1_reqs: got %0d expected 2", reqCount - base); end
    checks++;
    if (logAt(base) !== 32'h0001_0C00) begin errors++; $display("[TB] FAIL walk1_l1_addr: got %h expected 00010c00", logAt(base)); end
    checks++;
    if (logAt(base + 1) !== 32'h7AB4_0010) begin errors++; $display("[TB] FAIL walk1_l2_addr: got %h expected 7ab40010", logAt(base + 1)); end
  endtask

  task automatic test_l1_invalid();
    logic [31:0] pte, pteAcc;
    int cycles, base;
    bit to;
    base = reqCount;
    applyStimulus(32'hD000_0000, pte, pteAcc, cycles, to);
    checks++;
    if (pteAcc !== 32'h0) begin errors++; $display("[TB] FAIL l1inv_pte_cleared: got %h expected 0", pteAcc); end
    checks++;
    if (to !== 1'b0 || pte !== 32'h0) begin errors++; $display("[TB] FAIL l1inv_pte: got %h timeout=%b expected 0", pte, to); end
    checks++;
    if (reqCount - base !== 1) begin errors++; $display("[TB] FAIL l1inv_reqs: got %0d expected 1", reqCount - base); end
    checks++;
    if (logAt(base) !== 32'h0001_0D00) begin errors++; $display("[TB] FAIL l1inv_addr: got %h expected 00010d00", logAt(base)); end
  endtask

  task automatic test_l2_invalid();
    logic [31:0] pte, pteAcc;
    int cycles, base;
    bit to;
    base = reqCount;
    applyStimulus(32'hE000_1000, pte, pteAcc, cycles, to);
    checks++;
    if (to !== 1'b0 || pte !== 32'h0) begin errors++; $display("[TB] FAIL l2inv_pte: got %h timeout=%b expected 0", pte, to); end
    checks++;
    if (reqCount - base !== 2) begin errors++; $display("[TB] FAIL l2inv_reqs: got %0d expected 2", reqCount - base); end
    checks++;
    if (logAt(base + 1) !== 32'h0200_0004) begin errors++; $display("[TB] FAIL l2inv_l2_addr: got %h expected 02000004", logAt(base + 1)); end
  endtask

  task automatic test_write_only_l1();
    logic [31:0] pte, pteAcc;
    int cycles, base;
    bit to;
    base = reqCount;
    applyStimulus(32'h0040_0000, pte, pteAcc, cycles, to);
    checks++;
    if (to !== 1'b0 || pte !== 32'h0) begin errors++; $display("[TB] FAIL wonly_pte: got %h timeout=%b expected 0", pte, to); end
    checks++;
    if (reqCount - base !== 1) begin errors++; $display("[TB] FAIL wonly_reqs: got %0d expected 1", reqCount - base); end
  endtask

  task automatic test_stalls();
    int base, waitCnt;
    base = reqCount;
    mem_req_ready_i = 1'b0;
    ptw_req_valid_i = 1'b1;
    ptw_vaddr_i     = 32'hC000_4000;
    @(negedge clk);
    ptw_req_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (mem_req_valid_o !== 1'b1 || mem_addr_o !== 32'h0001_0C00) begin
        errors++;
        $display("[TB] FAIL stall_req_hold%0d: got valid=%b addr=%h expected 1/00010c00", i, mem_req_valid_o, mem_addr_o);
      end
      @(negedge clk);
    end
    mem_req_ready_i = 1'b1;
    waitCnt = 0;
    while (!ptw_resp_valid_o && waitCnt < 100) begin
      @(negedge clk);
      waitCnt++;
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ptw_resp_valid_o !== 1'b1 || ptw_pte_o !== 32'hBEEF_000B) begin
        errors++;
        $display("[TB] FAIL stall_resp_hold%0d: got valid=%b pte=%h expected 1/beef000b", i, ptw_resp_valid_o, ptw_pte_o);
      end
      @(negedge clk);
    end
    ptw_resp_ready_i = 1'b1;
    @(negedge clk);
    ptw_resp_ready_i = 1'b0;
    checks++;
    if (ptw_resp_valid_o !== 1'b0 || ptw_req_ready_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_release: got valid=%b ready=%b expected 0/1", ptw_resp_valid_o, ptw_req_ready_o);
    end
    checks++;
    if (reqCount - base !== 2) begin errors++; $display("[TB] FAIL stall_reqs: got %0d expected 2", reqCount - base); end
  endtask

  task automatic test_superpage();
    logic [31:0] pte, pteAcc;
    int cycles, base;
    bit to;
    base = reqCount;
    applyStimulus(32'hF000_0000, pte, pteAcc, cycles, to);
    checks++;
    if (to !== 1'b0 || pte !== SUPER_EXP) begin errors++; $display("[TB] FAIL superpage_pte: got %h timeout=%b expected %h", pte, to, SUPER_EXP); end
    checks++;
    if (reqCount - base !== 1) begin errors++; $display("[TB] FAIL superpage_reqs: got %0d expected 1", reqCount - base); end
  endtask

  task automatic test_reset_mid_walk();
    int waitCnt;
    respEnable      = 1'b0;
    ptw_req_valid_i = 1'b1;
    ptw_vaddr_i     = 32'hC000_4000;
    @(negedge clk);
    ptw_req_valid_i = 1'b0;
    waitCnt = 0;
    while (!mem_resp_ready_o && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    checks++;
    if (mem_resp_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL midrst_reach_wait: got %b expected 1", mem_resp_ready_o); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({ptw_req_ready_o, mem_resp_ready_o, mem_req_valid_o} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL midrst_abort: got %b expected 000", {ptw_req_ready_o, mem_resp_ready_o, mem_req_valid_o});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ptw_req_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL midrst_ready: got %b expected 1", ptw_req_ready_o); end
    respEnable      = 1'b1;
    manualRespValid = 1'b1;
    @(negedge clk);
    manualRespValid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({ptw_req_ready_o, ptw_resp_valid_o, mem_req_valid_o, mem_resp_ready_o} !== 4'b1000) begin
        errors++;
        $display("[TB] FAIL midrst_late_resp%0d: got %b expected 1000", i,
                 {ptw_req_ready_o, ptw_resp_valid_o, mem_req_valid_o, mem_resp_ready_o});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pte1, pte2, acc;
    int cycles;
    bit to1, to2;
    applyStimulus(32'hC000_4000, pte1, acc, cycles, to1);
    applyStimulus(32'hE000_1000, pte2, acc, cycles, to2);
    checks++;
    if (to1 !== 1'b0 || pte1 !== 32'hBEEF_000B) begin errors++; $display("[TB] FAIL b2b_first: got %h timeout=%b expected beef000b", pte1, to1); end
    checks++;
    if (to2 !== 1'b0 || pte2 !== 32'h0) begin errors++; $display("[TB] FAIL b2b_second: got %h timeout=%b expected 0", pte2, to2); end
  endtask

  initial begin
    memory[32'h0001_0C00] = 32'hDEAD_0001;
    memory[32'h7AB4_0010] = 32'hBEEF_000B;
    memory[32'h0001_0D00] = 32'h0000_0000;
    memory[32'h0001_0E00] = 32'h0080_0001;
    memory[32'h0200_0004] = 32'h0000_0000;
    memory[32'h0001_0004] = 32'h0000_0005;
    memory[32'h0001_0F00] = 32'h0040_000F;

    test_reset();
    test_two_level();
    test_l1_invalid();
    test_l2_invalid();
    test_write_only_l1();
    test_stalls();
    test_superpage();
    test_reset_mid_walk();
    test_back_to_back();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
